// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_resp data-memory responder.
package dmem_resp_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic {
        IDLE  = 1'b0,
        PEND1 = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        lane;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        err;
    } resp_ent_t;

endpackage

// File: rtl/dmem_resp_pipe.sv
// LAT-stage load-response shift register; valid and payload cleared by async reset.
module dmem_resp_pipe
    import dmem_resp_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic      clk,
    input  logic      rs_n,
    input  logic      in_vld,
    input  resp_ent_t in_ent,
    output logic      out_vld,
    output resp_ent_t out_ent
);

    logic [LAT:1] vld_pipe;
    resp_ent_t    ent_pipe [1:LAT];

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            vld_pipe <= '0;
            for (int s = 1; s <= LAT; s++) ent_pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            ent_pipe[1] <= in_ent;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                ent_pipe[s] <= ent_pipe[s-1];
            end
        end
    end

    assign out_vld = vld_pipe[LAT];
    assign out_ent = ent_pipe[LAT];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for two ALU lanes: one access per cycle, program order kept.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH),
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        rs_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [4:0]  tag0,
    input  logic [4:0]  tag1,
    output logic        ack0,
    output logic        ack1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [4:0]  rtag0,
    output logic [4:0]  rtag1,
    output logic        err0,
    output logic        err1
);

    arb_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // Lane 0 is older, so it wins a tie; lane 1 is then owed the next slot.
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0) begin
                    ack0 = 1'b1;
                    if (req1) state_nxt = PEND1;
                end else begin
                    ack1 = req1;
                end
            end
            PEND1: begin
                ack1      = req1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rs_n) begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end
    end

    logic          acc, sel1, a_we, mis;
    logic [31:0]   a_addr, a_wdata;
    logic [4:0]    a_tag;
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    assign acc     = ack0 | ack1;
    assign sel1    = ack1;
    assign a_we    = sel1 ? we1    : we0;
    assign a_addr  = sel1 ? addr1  : addr0;
    assign a_wdata = sel1 ? wdata1 : wdata0;
    assign a_tag   = sel1 ? tag1   : tag0;
    assign idx     = a_addr[AW+1:2];
    assign unused_addr_bits = ^{a_addr[31:AW+2], a_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (a_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Contents survive reset; only the response path is cleared.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (acc && a_we && !mis) mem[idx] <= a_wdata;
    end

    resp_ent_t in_ent, out_ent;
    logic      out_vld;

    always_comb begin
        in_ent      = '0;
        in_ent.lane = sel1;
        in_ent.tag  = a_tag;
        in_ent.data = mem[idx];
        in_ent.err  = mis;
    end

    dmem_resp_pipe #(.LAT(LAT)) u_pipe (
        .clk     (clk),
        .rs_n    (rs_n),
        .in_vld  (acc && !a_we),
        .in_ent  (in_ent),
        .out_vld (out_vld),
        .out_ent (out_ent)
    );

    logic [31:0] out_data;
    assign out_data = out_ent.err ? 32'h0 : out_ent.data;

    assign rvalid0 = out_vld && !out_ent.lane;
    assign rvalid1 = out_vld &&  out_ent.lane;
    assign rdata0  = rvalid0 ? out_data    : 32'h0;
    assign rdata1  = rvalid1 ? out_data    : 32'h0;
    assign rtag0   = rvalid0 ? out_ent.tag : 5'h0;
    assign rtag1   = rvalid1 ? out_ent.tag : 5'h0;

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            err0 <= acc && mis && !sel1;
            err1 <= acc && mis &&  sel1;
        end
    end
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: directed scenarios plus random two-lane traffic.
module tb_dmem_resp;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rs_n = 1'b0;
    logic req0, req1, we0, we1, ack0, ack1;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
    logic [4:0]  tag0, tag1, rtag0, rtag1;
    logic rvalid0, rvalid1, err0, err1;

    logic        r [2];
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [4:0]  t [2];

    assign req0 = r[0]; assign we0 = w[0]; assign addr0 = a[0]; assign wdata0 = d[0]; assign tag0 = t[0];
    assign req1 = r[1]; assign we1 = w[1]; assign addr1 = a[1]; assign wdata1 = d[1]; assign tag1 = t[1];

    dmem_resp #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
        .clk(clk), .rs_n(rs_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .tag0(tag0), .tag1(tag1), .ack0(ack0), .ack1(ack1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .rtag0(rtag0), .rtag1(rtag1), .err0(err0), .err1(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          lane;
        logic [4:0]  tag;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        expq [$];
    logic [31:0] mem_m [DEPTH];
    bit          owed = 1'b0;
    int          err_due [2] = '{-1, -1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].due < cyc) begin
            total++; bad++;
            $display("FAIL missing_rvalid: lane %0d due %0d now %0d", expq[0].lane, expq[0].due, cyc);
            void'(expq.pop_front());
        end
        chk("rvalid_excl", {31'h0, rvalid0 & rvalid1}, 32'h0);
        for (int l = 0; l < 2; l++) begin
            logic        rv;
            logic [31:0] rd;
            logic [4:0]  rt;
            exp_t        e;
            rv = (l == 0) ? rvalid0 : rvalid1;
            rd = (l == 0) ? rdata0  : rdata1;
            rt = (l == 0) ? rtag0   : rtag1;
            if (rv) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rvalid: lane %0d cycle %0d data %0h", l, cyc, rd);
                end else begin
                    e = expq.pop_front();
                    chk("resp_lane",  l,   e.lane);
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_data",  rd,  e.data);
                    chk("resp_tag",   {27'h0, rt}, {27'h0, e.tag});
                end
            end
        end
        chk("err0", {31'h0, err0}, {31'h0, (cyc == err_due[0])});
        chk("err1", {31'h0, err1}, {31'h0, (cyc == err_due[1])});
    end

    task automatic issue(input int l, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] tag);
        r[l] = 1'b1; w[l] = we; a[l] = addr; d[l] = data; t[l] = tag;
    endtask

    task automatic accept(input int l);
        logic [AW-1:0] idx;
        bit            mis;
        exp_t          e;
        idx = a[l][AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (a[l][1:0] != 2'b00);
        if (mis) err_due[l] = cyc + 1;
`else
        mis = 1'b0;
`endif
        if (w[l]) begin
            if (!mis) mem_m[idx] = d[l];
        end else begin
            e.lane = l;
            e.tag  = t[l];
            e.data = mis ? 32'h0 : mem_m[idx];
            e.due  = cyc + LAT;
            expq.push_back(e);
        end
    endtask

    // One cycle: predict grants from the ordering rules, check ack, advance.
    task automatic step(output bit g0, output bit g1);
        #1;
        if (!rs_n) begin
            g0 = 1'b0; g1 = 1'b0; owed = 1'b0;
        end else if (owed) begin
            g0 = 1'b0; g1 = r[1]; owed = 1'b0;
        end else begin
            g0 = r[0]; g1 = r[1] && !r[0]; owed = r[0] && r[1];
        end
        chk("ack0", {31'h0, ack0}, {31'h0, g0});
        chk("ack1", {31'h0, ack1}, {31'h0, g1});
        if (g0) accept(0);
        if (g1) accept(1);
        @(posedge clk);
        @(negedge clk);
        if (g0) r[0] = 1'b0;
        if (g1) r[1] = 1'b0;
    endtask

    task automatic tick();
        bit g0, g1;
        step(g0, g1);
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 20 && (expq.size() > 0 || r[0] || r[1]); i++) tick();
        tick();
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g0, g1;
        int wait1, stall0;
        for (int l = 0; l < 2; l++) begin
            r[l] = 1'b0; w[l] = 1'b0; a[l] = '0; d[l] = '0; t[l] = '0;
        end

        // Reset: ack suppressed even with a request, outputs quiet.
        repeat (2) @(negedge clk);
        r[0] = 1'b1; r[1] = 1'b1;
        #1;
        chk("rst_ack0", {31'h0, ack0}, 32'h0);
        chk("rst_ack1", {31'h0, ack1}, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rtag1", {27'h0, rtag1}, 32'h0);
        r[0] = 1'b0; r[1] = 1'b0;
        @(negedge clk);
        rs_n = 1'b1;
        @(negedge clk);

        // Store then load on lane 0.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0); tick();
        issue(0, 1'b0, 32'h10, 32'h0, 5'd8);        tick();
        drain();

        // Simultaneous sw lane 0 / lw lane 1 to the same word.
        issue(0, 1'b1, 32'h20, 32'd5, 5'd0);
        issue(1, 1'b0, 32'h20, 32'h0, 5'd9);
        tick(); tick();
        drain();

        // Lane 0 streams loads while lane 1 waits for its slot.
        wait1 = 0; stall0 = 0;
        issue(1, 1'b0, 32'h10, 32'h0, 5'd3);
        for (int i = 0; i < 5; i++) begin
            bit p0, p1;
            if (!r[0]) issue(0, 1'b0, 32'h20, 32'h0, 5'(10 + i));
            p0 = r[0]; p1 = r[1];
            step(g0, g1);
            if (p1) wait1++;
            if (p0 && !g0) stall0++;
        end
        chk("lane1_wait", wait1, 2);
        chk("lane0_stall", stall0, 1);
        drain();

        // Address wrap: 0x4000 aliases word 0.
        issue(0, 1'b1, 32'h0, 32'h12345678, 5'd0); tick();
        issue(0, 1'b0, 32'h4000, 32'h0, 5'd1);     tick();
        issue(1, 1'b0, 32'h0, 32'h0, 5'd2);        tick();
        drain();

        // Misaligned store and load.
        issue(0, 1'b1, 32'h13, 32'h0000CAFE, 5'd0); tick();
        issue(0, 1'b0, 32'h10, 32'h0, 5'd4);        tick();
        issue(1, 1'b0, 32'h11, 32'h0, 5'd5);        tick();
        drain();

        // Reset with a load in flight: dropped, memory retained.
        issue(0, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd0); tick();
        issue(0, 1'b0, 32'h40, 32'h0, 5'd6);        tick();
        #2;
        rs_n = 1'b0;
        expq.delete();
        owed = 1'b0;
        err_due[0] = -1; err_due[1] = -1;
        issue(0, 1'b0, 32'h40, 32'h0, 5'd6);
        #1;
        chk("midrst_ack0", {31'h0, ack0}, 32'h0);
        chk("midrst_rvalid0", {31'h0, rvalid0}, 32'h0);
        chk("midrst_rdata0", rdata0, 32'h0);
        repeat (2) @(negedge clk);
        r[0] = 1'b0;
        rs_n = 1'b1;
        repeat (LAT + 2) tick();
        issue(0, 1'b0, 32'h40, 32'h0, 5'd7); tick();
        drain();

        // Random traffic over a pre-written pool of words.
        for (int i = 0; i < 16; i++) begin
            issue(i % 2, 1'b1, 32'h100 + 32'(4 * i), $urandom, 5'd0);
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            for (int l = 0; l < 2; l++) begin
                if (!r[l] && $urandom_range(0, 99) < 60) begin
                    logic [31:0] ad;
                    ad = 32'h100 + 32'(4 * $urandom_range(0, 15));
                    ad = ad + (32'($urandom_range(0, 3)) << 14);
                    if ($urandom_range(0, 9) == 0) ad = ad + 32'($urandom_range(1, 3));
                    issue(l, ($urandom_range(0, 2) == 0), ad, $urandom, 5'($urandom_range(0, 31)));
                end
            end
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the memory end of the lw/sw request interface issued by the two ALU lanes (lane 0 = older instruction, lane 1 = younger).
- Accepts at most one word access per cycle and arbitrates so program order is preserved.
- Returns load data plus destination-register tag after a fixed latency, for write-back into regs.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of 2.
- AW, 12, word-index width = log2(DEPTH).
- LAT, 1, load latency in cycles from accept to rvalid; must be >= 1.

Ports:
- clk  in  1  clock; everything except ack0/ack1 is rising-edge.
- rs_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  lane request; held until acked.
- we0, we1  in  1  1 = sw, 0 = lw.
- addr0, addr1  in  32  byte address (r1 + sign-extended offset).
- wdata0, wdata1  in  32  store data.
- tag0, tag1  in  5  lw destination register.
- ack0, ack1  out  1  combinational grant; access is accepted on the edge where req&ack are both 1.
- rvalid0, rvalid1  out  1  one-cycle load-response pulse.
- rdata0, rdata1  out  32  load data, valid with rvalid.
- rtag0, rtag1  out  5  destination tag, valid with rvalid.
- err0, err1  out  1  one-cycle misalignment pulse (see Optional Feature).

Behaviour:
- Reset (async, rs_n=0):
  - FSM -> IDLE; response pipeline flushed; all registered outputs 0.
  - ack0/ack1 forced 0 while rs_n=0.
  - Memory contents are not cleared.
  - Reset mid-operation drops in-flight loads; no rvalid for them after release.
- FSM states: IDLE, PEND1.
  - IDLE, req0 only: ack0=1, stay IDLE.
  - IDLE, req1 only: ack1=1, stay IDLE.
  - IDLE, req0 and req1: ack0=1, ack1=0, go to PEND1.
  - PEND1: ack1=req1, ack0=0, so lane 0 stalls even if it raises a new req. Return to IDLE. If req1 has dropped (protocol violation), return to IDLE with no access.
- Addressing:
  - word index = addr[AW+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Store:
  - memory is written at the accept edge; no response, no rvalid.
- Load:
  - memory is read at the accept edge and goes through a LAT-deep pipe carrying data, tag and lane.
  - rvalid<lane> is high exactly LAT cycles after the accept edge; LAT=1 means the next cycle.
- Read-after-write:
  - sw accepted at edge k, then lw to the same word accepted at edge k+1: the lw returns the new data.
  - A lw can never be accepted in the same edge as a sw (one access per cycle).
- Back-to-back accepts every cycle are supported; the pipe holds LAT entries, and rvalid0 and rvalid1 are never high in the same cycle.
- Holding req low for a lane produces no activity for that lane.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: if addr[1:0]!=0 at acceptance, the access is still acked, but the store is suppressed and the load returns rdata=0 with normal rvalid/rtag. err<lane> pulses in the cycle after the accept.
- Undefined: addr[1:0] ignored; err0/err1 tied to 0.

Decomposition:
- Shared package: opcode constants OP_LW=6'b100011 and OP_SW=6'b101011, FSM state enum, response-pipe entry struct {lane, tag[4:0], data[31:0], err}.
- One natural sub-module: dmem_resp_pipe, a LAT-stage valid/data shift register with async clear.

Test Plan:
- sw lane0 addr=0x10 data=0xDEADBEEF, then lw lane0 addr=0x10 tag=8 -> rvalid0 one cycle after the lw accept, rdata0=0xDEADBEEF, rtag0=8.
- Same cycle: lane0 sw addr=0x20 data=5, lane1 lw addr=0x20 tag=9 -> ack0 first, then ack1 next cycle (PEND1); rdata1=5, rtag1=9.
- Lane0 requests continuously while lane1 requests -> lane1 acked within 2 cycles; lane0 stalled exactly 1 cycle in PEND1.
- lw addr=0x4000 vs addr=0x0 (DEPTH=4096) -> identical data, confirming wrap.
- rs_n pulsed low with a load in flight (LAT=3) -> no rvalid after release; outputs 0; memory data written earlier is still readable.
- With DMEM_MISALIGN_TRAP_EN: sw addr=0x13 -> err0 pulse, memory unchanged. Without it: the store writes word 4.
